adc_sample_framer: RTL and testbench

- Downstream consumer of the 24-bit two's-complement ADC output word.
- Samples the ADC word on an internal sample-rate tick and boxcar-decimates by 2^DECIM_LOG2.
- Buffers the averaged samples in a small FIFO and serializes each one as a byte stream, MSB first, with a valid/ready handshake toward the headstage link.

---
 rtl/adc_sample_framer.sv | 195 +++++++++++++++++++
 tb/tb_adc_sample_framer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_framer.sv
// ADC sample framer: tick-driven boxcar decimation, word FIFO and byte serializer toward the headstage link.
// Build option ADC_FRAMER_SEQ_TAG_EN prefixes every frame with an 8-bit sequence tag byte.
`timescale 1ns/1ps

module adc_sample_framer #(
  parameter int SAMPLE_DIV = 1000,
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [23:0]                   adc_data,
  output logic [7:0]                    out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          overflow_clr
);

  // state | meaning
  // IDLE  | no frame in flight, waiting for a FIFO word
  // TAG   | presenting the sequence tag byte (tag build only)
  // B2    | presenting hold[23:16]
  // B1    | presenting hold[15:8]
  // B0    | presenting hold[7:0], out_last high

  localparam int DIV_W = $clog2(SAMPLE_DIV);
  localparam int ACC_W = 24 + DECIM_LOG2;
  localparam int CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DECIM_LOG2) - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

`ifdef ADC_FRAMER_SEQ_TAG_EN
  typedef enum logic [2:0] {ST_IDLE, ST_TAG, ST_B2, ST_B1, ST_B0} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_B2, ST_B1, ST_B0} state_t;
`endif

  logic [DIV_W-1:0]        div_cnt;
  logic                    tick;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] adc_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic [CNT_W-1:0]        samp_cnt;
  logic                    last_samp;
  logic                    push_req;
  logic [23:0]             push_word;

  logic [23:0]             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [LVL_W-1:0]        level;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    push_ok;
  logic                    pop;
  logic [23:0]             fifo_rdata;

  state_t                  state;
  logic [23:0]             hold;
  logic                    byte_acc;
`ifdef ADC_FRAMER_SEQ_TAG_EN
  logic [7:0]              seq_cnt;
`endif

  // Sample-rate divider; held at zero while stopped so the first tick is a full period after enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (!enable || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick      = enable && (div_cnt == DIV_LAST);
  assign last_samp = (samp_cnt == CNT_LAST);
  assign push_req  = tick && last_samp;

  assign adc_ext   = ACC_W'($signed(adc_data));
  assign acc_sum   = acc_q + adc_ext;
  assign push_word = 24'(acc_sum >>> DECIM_LOG2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      samp_cnt <= '0;
    end else if (!enable || push_req) begin
      acc_q    <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      acc_q    <= acc_sum;
      samp_cnt <= samp_cnt + 1'b1;
    end
  end

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == LVL_FULL);
  assign fifo_rdata = mem[rd_ptr];
  assign byte_acc   = out_valid && out_ready;
  // A pop frees a slot in the same cycle, so a push into a full FIFO still lands.
  assign pop        = !fifo_empty && ((state == ST_IDLE) || (state == ST_B0 && byte_acc));
  assign push_ok    = push_req && (!fifo_full || pop);
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (push_req && fifo_full && !pop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      hold      <= '0;
      out_byte  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
`ifdef ADC_FRAMER_SEQ_TAG_EN
      seq_cnt   <= '0;
`endif
    end else if (pop) begin
      // Entered from IDLE or from an accepted B0, which gives gapless back-to-back frames.
      hold      <= fifo_rdata;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
`ifdef ADC_FRAMER_SEQ_TAG_EN
      state     <= ST_TAG;
      out_byte  <= seq_cnt;
`else
      state     <= ST_B2;
      out_byte  <= fifo_rdata[23:16];
`endif
    end else if (byte_acc) begin
      case (state)
`ifdef ADC_FRAMER_SEQ_TAG_EN
        ST_TAG: begin
          state    <= ST_B2;
          out_byte <= hold[23:16];
          seq_cnt  <= seq_cnt + 1'b1;
        end
`endif
        ST_B2: begin
          state    <= ST_B1;
          out_byte <= hold[15:8];
        end
        ST_B1: begin
          state    <= ST_B0;
          out_byte <= hold[7:0];
          out_last <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          out_byte  <= '0;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_sample_framer.sv
// Self-checking bench for adc_sample_framer: a behavioural decimation model feeds a scoreboard of expected words.
// Build with ADC_FRAMER_SEQ_TAG_EN defined to also check the frame tag byte.
`timescale 1ns/1ps

module tb_adc_sample_framer;

  localparam int SD = 4;
  localparam int DL = 2;
  localparam int FD = 8;
  localparam int LW = $clog2(FD) + 1;
  localparam int NS = 1 << DL;
`ifdef ADC_FRAMER_SEQ_TAG_EN
  localparam int FB = 4;
`else
  localparam int FB = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          enable = 1'b0;
  logic [23:0]   adc_data = '0;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [LW-1:0] fifo_level;
  logic          overflow;
  logic          overflow_clr = 1'b0;

  int vecs = 0;
  int miss = 0;
  int cyc = 0;

  adc_sample_framer #(.SAMPLE_DIV(SD), .DECIM_LOG2(DL), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_data(adc_data),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .fifo_level(fifo_level), .overflow(overflow), .overflow_clr(overflow_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural model: divider, running sum and floor-average by integer division.
  int          m_div = 0;
  int          m_cnt = 0;
  longint      m_acc = 0;
  int          n_pushed = 0;
  int          push_cap = 1 << 30;
  logic [23:0] sb[$];

  function automatic logic [23:0] floor_avg(input longint s);
    longint q;
    q = s / NS;
    if ((s % NS) != 0 && s < 0) q = q - 1;
    return q[23:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_div <= 0;
      m_cnt <= 0;
      m_acc <= 0;
      sb.delete();
    end else if (!enable) begin
      m_div <= 0;
      m_cnt <= 0;
      m_acc <= 0;
    end else if (m_div != SD - 1) begin
      m_div <= m_div + 1;
    end else begin
      m_div <= 0;
      if (m_cnt == NS - 1) begin
        if (n_pushed < push_cap) sb.push_back(floor_avg(m_acc + longint'($signed(adc_data))));
        n_pushed <= n_pushed + 1;
        m_cnt <= 0;
        m_acc <= 0;
      end else begin
        m_cnt <= m_cnt + 1;
        m_acc <= m_acc + longint'($signed(adc_data));
      end
    end
  end

  // Monitor: assembles accepted bytes into frames and records handshake anomalies.
  logic [23:0] rx_word[$];
  int          rx_time[$];
  int          byte_idx = 0;
  logic [15:0] cur = '0;
  int          last_bad = 0;
  int          stab_bad = 0;
  logic        stalled = 1'b0;
  logic [7:0]  stall_byte = '0;
`ifdef ADC_FRAMER_SEQ_TAG_EN
  logic [7:0]  rx_tag[$];
  logic [7:0]  cur_tag = '0;
`endif

  always @(negedge clk) begin
    if (!rst_n) begin
      byte_idx <= 0;
      stalled  <= 1'b0;
    end else begin
      if (stalled && (!out_valid || out_byte != stall_byte)) stab_bad <= stab_bad + 1;
      stalled    <= out_valid && !out_ready;
      stall_byte <= out_byte;
      if (out_valid && out_ready) begin
        if (out_last != (byte_idx == FB - 1)) last_bad <= last_bad + 1;
`ifdef ADC_FRAMER_SEQ_TAG_EN
        if (byte_idx == 0) cur_tag <= out_byte;
        else cur <= {cur[7:0], out_byte};
`else
        cur <= {cur[7:0], out_byte};
`endif
        if (byte_idx == FB - 1) begin
          rx_word.push_back({cur, out_byte});
          rx_time.push_back(cyc);
`ifdef ADC_FRAMER_SEQ_TAG_EN
          rx_tag.push_back(cur_tag);
`endif
          byte_idx <= 0;
        end else begin
          byte_idx <= byte_idx + 1;
        end
      end
    end
  end

  logic [7:0] exp_tag = '0;

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_rx(input int n, input int budget, output bit ok);
    int t = 0;
    while (rx_word.size() < n && t < budget) begin
      tick_n(1);
      t++;
    end
    ok = (rx_word.size() >= n);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    tick_n(3);
    rst_n = 1'b1;
    tick_n(2);
    vecs++; if (out_valid !== 1'b0) begin miss++; $display("FAIL reset_valid got %b want 0", out_valid); end
    vecs++; if (out_byte !== 8'h00) begin miss++; $display("FAIL reset_byte got %h want 00", out_byte); end
    vecs++; if (out_last !== 1'b0) begin miss++; $display("FAIL reset_last got %b want 0", out_last); end
    vecs++; if (fifo_level !== '0) begin miss++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    vecs++; if (overflow !== 1'b0) begin miss++; $display("FAIL reset_overflow got %b want 0", overflow); end
  endtask

  task automatic test_basic;
    bit ok;
    logic [23:0] w, e;
    int t0;
    rx_time.delete();
    adc_data = 24'h7FFFFF;
    out_ready = 1'b1;
    enable = 1'b1;
    wait_rx(4, 200, ok);
    vecs++; if (!ok) begin miss++; $display("FAIL basic_timeout got %0d frames want 4", rx_word.size()); end
    enable = 1'b0;
    tick_n(30);
    t0 = rx_time.pop_front();
    for (int k = 1; k < 4 && rx_time.size() > 0; k++) begin
      vecs++;
      if (rx_time[0] - t0 !== 16) begin miss++; $display("FAIL basic_period got %0d want 16", rx_time[0] - t0); end
      t0 = rx_time.pop_front();
    end
    while (rx_word.size() > 0) begin
      w = rx_word.pop_front();
      vecs++; if (w !== 24'h7FFFFF) begin miss++; $display("FAIL basic_word got %h want 7fffff", w); end
      vecs++;
      if (sb.size() == 0) begin miss++; $display("FAIL basic_sb got %h want none", w); end
      else begin e = sb.pop_front(); if (w !== e) begin miss++; $display("FAIL basic_sb got %h want %h", w, e); end end
`ifdef ADC_FRAMER_SEQ_TAG_EN
      vecs++; if (rx_tag[0] !== exp_tag) begin miss++; $display("FAIL basic_tag got %h want %h", rx_tag[0], exp_tag); end
      void'(rx_tag.pop_front());
`endif
      exp_tag++;
    end
    vecs++; if (last_bad !== 0) begin miss++; $display("FAIL basic_last got %0d bad want 0", last_bad); end
    vecs++; if (sb.size() !== 0) begin miss++; $display("FAIL basic_pending got %0d want 0", sb.size()); end
  endtask

  task automatic test_negative;
    bit ok;
    logic [23:0] w, e;
    adc_data = 24'hFFFFFD;
    enable = 1'b1;
    tick_n(4);
    adc_data = 24'hFFFFFE;
    tick_n(12);
    enable = 1'b0;
    wait_rx(1, 50, ok);
    tick_n(5);
    vecs++; if (!ok) begin miss++; $display("FAIL neg_timeout got %0d frames want 1", rx_word.size()); end
    while (rx_word.size() > 0) begin
      w = rx_word.pop_front();
      vecs++; if (w !== 24'hFFFFFD) begin miss++; $display("FAIL neg_word got %h want fffffd", w); end
      vecs++;
      if (sb.size() == 0) begin miss++; $display("FAIL neg_sb got %h want none", w); end
      else begin e = sb.pop_front(); if (w !== e) begin miss++; $display("FAIL neg_sb got %h want %h", w, e); end end
`ifdef ADC_FRAMER_SEQ_TAG_EN
      void'(rx_tag.pop_front());
`endif
      exp_tag++;
    end
  endtask

  task automatic test_enable_drop;
    bit ok;
    logic [23:0] w, e;
    int nf = 0;
    adc_data = 24'h400000;
    enable = 1'b1;
    tick_n(8);
    enable = 1'b0;
    tick_n(2);
    adc_data = 24'h000010;
    enable = 1'b1;
    tick_n(16);
    enable = 1'b0;
    wait_rx(1, 40, ok);
    tick_n(10);
    vecs++; if (!ok) begin miss++; $display("FAIL endrop_timeout got %0d frames want 1", rx_word.size()); end
    while (rx_word.size() > 0) begin
      w = rx_word.pop_front();
      nf++;
      vecs++; if (w !== 24'h000010) begin miss++; $display("FAIL endrop_word got %h want 000010", w); end
      vecs++;
      if (sb.size() == 0) begin miss++; $display("FAIL endrop_sb got %h want none", w); end
      else begin e = sb.pop_front(); if (w !== e) begin miss++; $display("FAIL endrop_sb got %h want %h", w, e); end end
`ifdef ADC_FRAMER_SEQ_TAG_EN
      void'(rx_tag.pop_front());
`endif
      exp_tag++;
    end
    vecs++; if (nf !== 1) begin miss++; $display("FAIL endrop_count got %0d want 1", nf); end
  endtask

  task automatic test_toggle;
    logic [23:0] w, e;
    int nf = 0;
    int s0 = stab_bad;
    enable = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (i % 4 == 0) adc_data = 24'($urandom);
      out_ready = ~out_ready;
      tick_n(1);
    end
    enable = 1'b0;
    out_ready = 1'b1;
    tick_n(30);
    vecs++; if (stab_bad !== s0) begin miss++; $display("FAIL toggle_stable got %0d unstable want %0d", stab_bad, s0); end
    while (rx_word.size() > 0) begin
      w = rx_word.pop_front();
      nf++;
      vecs++;
      if (sb.size() == 0) begin miss++; $display("FAIL toggle_sb got %h want none", w); end
      else begin e = sb.pop_front(); if (w !== e) begin miss++; $display("FAIL toggle_sb got %h want %h", w, e); end end
`ifdef ADC_FRAMER_SEQ_TAG_EN
      vecs++; if (rx_tag[0] !== exp_tag) begin miss++; $display("FAIL toggle_tag got %h want %h", rx_tag[0], exp_tag); end
      void'(rx_tag.pop_front());
`endif
      exp_tag++;
    end
    vecs++; if (nf !== 7) begin miss++; $display("FAIL toggle_count got %0d want 7", nf); end
    vecs++; if (last_bad !== 0) begin miss++; $display("FAIL toggle_last got %0d bad want 0", last_bad); end
  endtask

  task automatic test_stall;
    bit ok;
    logic [23:0] w, e;
    int nf = 0;
    out_ready = 1'b0;
    // One word goes to the serializer hold register, eight fill the FIFO, the rest are dropped.
    push_cap = n_pushed + FD + 1;
    enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      adc_data = 24'($urandom);
      tick_n(1);
    end
    vecs++; if (fifo_level !== LW'(FD)) begin miss++; $display("FAIL stall_level got %0d want %0d", fifo_level, FD); end
    vecs++; if (overflow !== 1'b1) begin miss++; $display("FAIL stall_overflow got %b want 1", overflow); end
    enable = 1'b0;
    tick_n(2);
    push_cap = 1 << 30;
    out_ready = 1'b1;
    wait_rx(FD + 1, 300, ok);
    tick_n(20);
    vecs++; if (!ok) begin miss++; $display("FAIL stall_timeout got %0d frames want %0d", rx_word.size(), FD + 1); end
    while (rx_word.size() > 0) begin
      w = rx_word.pop_front();
      nf++;
      vecs++;
      if (sb.size() == 0) begin miss++; $display("FAIL stall_sb got %h want none", w); end
      else begin e = sb.pop_front(); if (w !== e) begin miss++; $display("FAIL stall_sb got %h want %h", w, e); end end
`ifdef ADC_FRAMER_SEQ_TAG_EN
      vecs++; if (rx_tag[0] !== exp_tag) begin miss++; $display("FAIL stall_tag got %h want %h", rx_tag[0], exp_tag); end
      void'(rx_tag.pop_front());
`endif
      exp_tag++;
    end
    vecs++; if (nf !== FD + 1) begin miss++; $display("FAIL stall_count got %0d want %0d", nf, FD + 1); end
    vecs++; if (fifo_level !== '0) begin miss++; $display("FAIL stall_drained got %0d want 0", fifo_level); end
    vecs++; if (overflow !== 1'b1) begin miss++; $display("FAIL stall_sticky got %b want 1", overflow); end
    overflow_clr = 1'b1;
    tick_n(1);
    overflow_clr = 1'b0;
    vecs++; if (overflow !== 1'b0) begin miss++; $display("FAIL stall_clr got %b want 0", overflow); end
  endtask

  task automatic test_reset_midframe;
    bit ok;
    bit found = 1'b0;
    logic [23:0] w, e;
    int nf = 0;
    adc_data = 24'h123456;
    out_ready = 1'b1;
    enable = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      tick_n(1);
      if (out_valid && byte_idx == FB - 2) found = 1'b1;
    end
    vecs++; if (!found) begin miss++; $display("FAIL rstmid_reach got 0 want 1"); end
    out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    vecs++; if (out_valid !== 1'b0) begin miss++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    vecs++; if (out_byte !== 8'h00) begin miss++; $display("FAIL rstmid_byte got %h want 00", out_byte); end
    vecs++; if (out_last !== 1'b0) begin miss++; $display("FAIL rstmid_last got %b want 0", out_last); end
    vecs++; if (fifo_level !== '0) begin miss++; $display("FAIL rstmid_level got %0d want 0", fifo_level); end
    enable = 1'b0;
    tick_n(2);
    rx_word.delete();
`ifdef ADC_FRAMER_SEQ_TAG_EN
    rx_tag.delete();
`endif
    exp_tag = '0;
    rst_n = 1'b1;
    tick_n(1);
    adc_data = 24'h0ABCDE;
    out_ready = 1'b1;
    enable = 1'b1;
    wait_rx(3, 150, ok);
    enable = 1'b0;
    tick_n(20);
    vecs++; if (!ok) begin miss++; $display("FAIL rstmid_timeout got %0d frames want 3", rx_word.size()); end
    while (rx_word.size() > 0) begin
      w = rx_word.pop_front();
      nf++;
      vecs++; if (w !== 24'h0ABCDE) begin miss++; $display("FAIL rstmid_word got %h want 0abcde", w); end
      vecs++;
      if (sb.size() == 0) begin miss++; $display("FAIL rstmid_sb got %h want none", w); end
      else begin e = sb.pop_front(); if (w !== e) begin miss++; $display("FAIL rstmid_sb got %h want %h", w, e); end end
`ifdef ADC_FRAMER_SEQ_TAG_EN
      vecs++; if (rx_tag[0] !== exp_tag) begin miss++; $display("FAIL rstmid_tag got %h want %h", rx_tag[0], exp_tag); end
      void'(rx_tag.pop_front());
`endif
      exp_tag++;
    end
    vecs++; if (nf < 3) begin miss++; $display("FAIL rstmid_count got %0d want >=3", nf); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_negative;
    test_enable_drop;
    test_toggle;
    test_stall;
    test_reset_midframe;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
